// File: rtl/fifo_pkg.sv
// Shared constants and types for the byte FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH  = 8;
  localparam int FIFO_DEPTH       = 8;
  localparam int FIFO_COUNT_WIDTH = 4;
  localparam int FIFO_PTR_WIDTH   = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_PTR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO: one synchronous write port and one
// synchronous read port whose output register is the FIFO's Data_out.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PTR_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [PTR_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read data register; holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data, count and flags.
// Optional overflow/underflow pulse outputs are enabled by FIFO_ERR_FLAGS_EN.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int DEPTH       = FIFO_DEPTH,
  parameter int COUNT_WIDTH = FIFO_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  Data_in,
  input  logic                   rd,
  input  logic                   wr,
  output logic                   empty,
  output logic                   full,
  output logic [COUNT_WIDTH-1:0] count,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                   overflow,
  output logic                   underflow,
`endif
  output logic [DATA_WIDTH-1:0]  Data_out
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);

  logic [PTR_WIDTH-1:0]   wr_ptr_r;
  logic [PTR_WIDTH-1:0]   rd_ptr_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [COUNT_WIDTH-1:0] count_next_s;
  logic                   empty_r;
  logic                   full_r;
  logic                   rd_accept_s;
  logic                   wr_accept_s;

  // A write into a full FIFO is only legal when a read frees a slot the same edge.
  always_comb begin
    rd_accept_s = rd && !empty_r;
    wr_accept_s = wr && (!full_r || rd_accept_s);
  end

  // Occupancy update from the accepted operations.
  always_comb begin
    count_next_s = count_r;
    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_next_s = count_r + COUNT_WIDTH'(1);
      2'b01:   count_next_s = count_r - COUNT_WIDTH'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and flags; flags are registered from the next count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_WIDTH{1'b0}};
      rd_ptr_r <= {PTR_WIDTH{1'b0}};
      count_r  <= {COUNT_WIDTH{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_accept_s ? wr_ptr_r + PTR_WIDTH'(1) : wr_ptr_r;
      rd_ptr_r <= rd_accept_s ? rd_ptr_r + PTR_WIDTH'(1) : rd_ptr_r;
      count_r  <= count_next_s;
      empty_r  <= (count_next_s == {COUNT_WIDTH{1'b0}});
      full_r   <= (count_next_s == COUNT_FULL);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept_s),
    .wr_addr (wr_ptr_r),
    .wr_data (Data_in),
    .rd_en   (rd_accept_s),
    .rd_addr (rd_ptr_r),
    .rd_data (Data_out)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // One-cycle pulses for rejected requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= wr && !wr_accept_s;
      underflow_r <= rd && !rd_accept_s;
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

  assign empty = empty_r;
  assign full  = full_r;
  assign count = count_r;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Data_in;
  logic       rd;
  logic       wr;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic [7:0] Data_out;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  always #5 clk = ~clk;

  fifo dut (
    .clk      (clk),
    .rst      (rst),
    .Data_in  (Data_in),
    .rd       (rd),
    .wr       (wr),
    .empty    (empty),
    .full     (full),
    .count    (count),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .Data_out (Data_out)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of stored bytes plus the last value read out.
  byte unsigned q[$];
  logic [7:0]   m_dout = 8'd0;
  logic         m_ovf  = 1'b0;
  logic         m_udf  = 1'b0;

  typedef struct {
    logic       r;
    logic       w;
    logic       rdq;
    logic [7:0] din;
    int         exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic rdq, input logic [7:0] d);
    bit rok;
    bit wok;
    if (!r) begin
      q.delete();
      m_dout = 8'd0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      rok   = rdq && (q.size() != 0);
      wok   = w && ((q.size() < FIFO_DEPTH) || rok);
      m_ovf = w && !wok;
      m_udf = rdq && !rok;
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic rdq, input logic [7:0] d);
    rst     = r;
    wr      = w;
    rd      = rdq;
    Data_in = d;
    @(posedge clk);
    #1;
    model_step(r, w, rdq, d);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, {28'd0, count}, q.size());
    chk({tag, "_empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
    chk({tag, "_full"},  {31'd0, full},  {31'd0, q.size() == FIFO_DEPTH});
    chk({tag, "_dout"},  {24'd0, Data_out}, {24'd0, m_dout});
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, "_ovf"}, {31'd0, overflow},  {31'd0, m_ovf});
    chk({tag, "_udf"}, {31'd0, underflow}, {31'd0, m_udf});
`endif
  endtask

  task automatic cyc(input logic r, input logic w, input logic rdq, input logic [7:0] d, input string tag);
    drive(r, w, rdq, d);
    check_model(tag);
  endtask

  initial begin
    rst     = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    Data_in = 8'd0;

    // Directed table: reset, four writes, drain, then reads on an empty FIFO.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  0, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd10, 1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd20, 2, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd30, 3, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd40, 4, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'd0,  3, 1'b0, 1'b0, 8'd10});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'd0,  2, 1'b0, 1'b0, 8'd20});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'd0,  1, 1'b0, 1'b0, 8'd30});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'd0,  0, 1'b1, 1'b0, 8'd40});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'd0,  0, 1'b1, 1'b0, 8'd40});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'd0,  0, 1'b1, 1'b0, 8'd40});

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].w, vecs[i].rdq, vecs[i].din);
      chk($sformatf("tbl%0d_count", i), {28'd0, count}, vecs[i].exp_count);
      chk($sformatf("tbl%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_empty});
      chk($sformatf("tbl%0d_full", i),  {31'd0, full},  {31'd0, vecs[i].exp_full});
      chk($sformatf("tbl%0d_dout", i),  {24'd0, Data_out}, {24'd0, vecs[i].exp_dout});
`ifdef FIFO_ERR_FLAGS_EN
      chk($sformatf("tbl%0d_udf", i), {31'd0, underflow}, {31'd0, (i >= 9)});
`endif
    end

    // Fill/drain twice so both pointers wrap; first pass also does rd+wr while full.
    for (int rep = 0; rep < 2; rep++) begin
      for (int v = 1; v <= 9; v++) begin
        cyc(1'b1, 1'b1, 1'b0, 8'(v), $sformatf("fill%0d_%0d", rep, v));
        if (v == 8) begin
          chk($sformatf("fill%0d_full8", rep), {31'd0, full}, 32'd1);
          chk($sformatf("fill%0d_cnt8", rep), {28'd0, count}, 32'd8);
        end
      end
      if (rep == 0) begin
        cyc(1'b1, 1'b1, 1'b1, 8'd99, "full_rdwr");
        chk("full_rdwr_cnt", {28'd0, count}, 32'd8);
        chk("full_rdwr_dout", {24'd0, Data_out}, 32'd1);
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 1'b1, 8'd0, $sformatf("drainA_%0d", k));
        chk("drainA_last99", {24'd0, Data_out}, 32'd99);
      end else begin
        for (int k = 0; k < 8; k++) begin
          cyc(1'b1, 1'b0, 1'b1, 8'd0, $sformatf("drainB_%0d", k));
          chk($sformatf("drainB_val%0d", k), {24'd0, Data_out}, k + 1);
        end
      end
      cyc(1'b1, 1'b0, 1'b1, 8'd0, $sformatf("drain_empty%0d", rep));
    end

    // Simultaneous rd+wr while empty: write only, Data_out unchanged.
    cyc(1'b1, 1'b1, 1'b1, 8'd55, "empty_rdwr");
    chk("empty_rdwr_cnt", {28'd0, count}, 32'd1);
    chk("empty_rdwr_dout", {24'd0, Data_out}, 32'd8);
    cyc(1'b1, 1'b0, 1'b1, 8'd0, "read55");
    chk("read55_dout", {24'd0, Data_out}, 32'd55);

    // Reset mid-operation discards the concurrent request.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 8'(k + 70), "pre_rst");
    cyc(1'b0, 1'b1, 1'b1, 8'd7, "mid_rst");
    chk("mid_rst_cnt", {28'd0, count}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'd0, "post_rst_rd");

    // Randomized traffic with alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int p;
      logic r_s, w_s, rd_s;
      p    = ((i / 150) % 2 == 1) ? 80 : 25;
      r_s  = ($urandom_range(0, 199) != 0);
      w_s  = ($urandom_range(0, 99) < p);
      rd_s = ($urandom_range(0, 99) < (100 - p));
      cyc(r_s, w_s, rd_s, 8'($urandom_range(0, 255)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
